// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: drain FSM states and the
// map/address sizing helpers used by control, datapath and result drain.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    function automatic int map_words(input int w, input int h);
        return w * h;
    endfunction

    function automatic int map_addr_width(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    function automatic int chan_addr_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/conv_drain_queue.sv
// Small register-based FIFO that buffers result words returning from the
// BRAMs; the head is read straight from the storage registers.
module conv_drain_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && !w_full;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// Streams a finished output feature map out of the per-channel result BRAMs,
// channel-major, with a credit-limited prefetch queue hiding read latency.
module conv_result_drain
    import conv_pkg::*;
#(
    parameter int SUM_WIDTH             = 48,
    parameter int RESULT_W              = 14,
    parameter int RESULT_H              = 14,
    parameter int RESULT_D              = 8,
    parameter int RAM_LATENCY           = 2,
    parameter int QDEPTH                = RAM_LATENCY + 1,
    parameter int RESULT_RAM_ADDR_WIDTH = map_addr_width(RESULT_W, RESULT_H),
    parameter int RESULT_D_ADDR_WIDTH   = chan_addr_width(RESULT_D)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0]  result_rdaddress,
    output logic                              result_rden,
    input  logic [SUM_WIDTH*RESULT_D-1:0]     result_rddata,
    output logic [SUM_WIDTH-1:0]              out_data,
    output logic [RESULT_D_ADDR_WIDTH-1:0]    out_chan,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic                              out_last
);

    localparam int N  = map_words(RESULT_W, RESULT_H);
    localparam int AW = RESULT_RAM_ADDR_WIDTH;
    localparam int DW = RESULT_D_ADDR_WIDTH;
    localparam int QW = SUM_WIDTH + DW + 1;
    localparam int CW = count_width(QDEPTH);
    localparam int L  = RAM_LATENCY;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [DW-1:0] LAST_CHAN = DW'(RESULT_D - 1);

    drain_state_t              r_state;
    logic                      r_busy;
    logic                      r_done;
    logic [AW-1:0]             r_addr;
    logic [DW-1:0]             r_chan;
    logic [CW-1:0]             r_inflight;
    logic [L-1:0]              r_pipe_vld;
    logic [L-1:0]              r_pipe_last;
    logic [L-1:0][DW-1:0]      r_pipe_chan;

    logic [SUM_WIDTH-1:0]      w_slice [RESULT_D];
    logic [SUM_WIDTH-1:0]      w_arr_data;
    logic [QW-1:0]             w_head;
    logic [CW-1:0]             w_q_count;
    logic                      w_q_empty;
    logic                      w_pop;
    logic                      w_arrive;
    logic                      w_rden;
    logic                      w_last_issue;
    logic                      w_accept;
    logic                      w_finish;
    logic [CW:0]               w_occupancy;

    for (genvar gi = 0; gi < RESULT_D; gi++) begin : g_slice
        assign w_slice[gi] = result_rddata[gi*SUM_WIDTH +: SUM_WIDTH];
    end

    assign w_arrive   = r_pipe_vld[L-1];
    assign w_arr_data = w_slice[r_pipe_chan[L-1]];
    assign out_val    = !w_q_empty;
    assign w_pop      = out_val && out_rdy;

    // A word leaving the queue this cycle frees its slot for the read issued now.
    assign w_occupancy  = (CW+1)'(w_q_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_rden       = (r_state == ST_READ) && (w_occupancy < (CW+1)'(QDEPTH));
    assign w_last_issue = w_rden && (r_addr == LAST_ADDR) && (r_chan == LAST_CHAN);
    // The done cycle already sits in IDLE, so a start there must still be refused.
    assign w_accept     = start && (r_state == ST_IDLE) && !r_done;
    assign w_finish     = (r_state == ST_FLUSH) && w_pop && out_last
                          && (r_inflight == '0) && (w_q_count == CW'(1));

    assign result_rden      = w_rden;
    assign result_rdaddress = r_addr;
    assign busy             = r_busy;
    assign done             = r_done;
    assign out_data         = w_head[QW-1 -: SUM_WIDTH];
    assign out_chan         = w_head[1 +: DW];
    assign out_last         = w_head[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_READ;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_last_issue) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_finish) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_chan <= '0;
        end else if (w_accept) begin
            r_addr <= '0;
            r_chan <= '0;
        end else if (w_rden) begin
            if (r_addr == LAST_ADDR) begin
                r_addr <= '0;
                r_chan <= (r_chan == LAST_CHAN) ? '0 : r_chan + DW'(1);
            end else begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_rden, w_arrive})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Channel and last flag ride alongside each read so they meet its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_pipe_chan <= '0;
        end else begin
            r_pipe_vld[0]  <= w_rden;
            r_pipe_last[0] <= w_last_issue;
            r_pipe_chan[0] <= r_chan;
            for (int i = 1; i < L; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
                r_pipe_chan[i] <= r_pipe_chan[i-1];
            end
        end
    end

    conv_drain_queue #(
        .WIDTH (QW),
        .DEPTH (QDEPTH),
        .CNT_W (CW)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_arrive),
        .i_data  ({w_arr_data, r_pipe_chan[L-1], r_pipe_last[L-1]}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

endmodule

// File: tb/tb_conv_result_drain.sv
// Scoreboard bench: three 2x2x2 builds (latency 1, 2, 3) and one 14x14x8 build,
// each with its own BRAM model, expected-word queue and monitor.
module tb_conv_result_drain;

    localparam int SW = 48;

    typedef struct packed {
        logic [47:0] data;
        logic [2:0]  chan;
        logic        last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       s_start [4];
    logic       s_rdy   [4];
    logic       s_load  [4];
    logic       s_free  [4];
    logic [7:0] s_outs  [4];   // {busy, done, rden, val, last, |chan, |addr, |data}

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    longint ramp_data [8] = '{0, 1, 2, 3, 100, 101, 102, 103};
    int     ramp_chan [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    always @(posedge clk) cyc++;

    task automatic check(input int k, input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %0d, required %0d", k, name, act, exp_v);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W  = (gi == 3) ? 14 : 2;
        localparam int D  = (gi == 3) ? 8 : 2;
        localparam int L  = (gi == 0) ? 1 : (gi == 2) ? 3 : 2;
        localparam int N  = W * W;
        localparam int AW = $clog2(N);
        localparam int DW = $clog2(D);

        logic          busy, done, rden, out_val, out_last;
        logic [AW-1:0] rdaddr;
        logic [SW*D-1:0] rddata;
        logic [SW-1:0] out_data;
        logic [DW-1:0] out_chan;
        logic [AW-1:0] ram_pipe [L];
        exp_t          sb [$];
        exp_t          e_cur;
        int            t_start, t_rden, t_val, iss, acc, nword;

        conv_result_drain #(
            .SUM_WIDTH   (SW),
            .RESULT_W    (W),
            .RESULT_H    (W),
            .RESULT_D    (D),
            .RAM_LATENCY (L)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .start            (s_start[gi]),
            .busy             (busy),
            .done             (done),
            .result_rdaddress (rdaddr),
            .result_rden      (rden),
            .result_rddata    (rddata),
            .out_data         (out_data),
            .out_chan         (out_chan),
            .out_val          (out_val),
            .out_rdy          (s_rdy[gi]),
            .out_last         (out_last)
        );

        assign s_outs[gi] = {busy, done, rden, out_val, out_last, |out_chan, |rdaddr, |out_data};

        // BRAM model: channel c holds 100*c + address, L cycles of read latency.
        always @(posedge clk) begin
            ram_pipe[0] <= rdaddr;
            for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
        end

        always_comb begin
            rddata = '0;
            for (int c = 0; c < D; c++) rddata[c*SW +: SW] = SW'(100 * c) + SW'(ram_pipe[L-1]);
        end

        always @(negedge clk) begin
            if (!reset) begin
                sb.delete();
                iss    = 0;
                acc    = 0;
                t_rden = -1;
                t_val  = -1;
            end else begin
                if (s_load[gi]) begin
                    t_start = cyc;
                    t_rden  = -1;
                    t_val   = -1;
                    iss     = 0;
                    acc     = 0;
                    nword   = 0;
                    for (int c = 0; c < D; c++) begin
                        for (int a = 0; a < N; a++) begin
                            e_cur.data = (gi == 3) ? 48'(100 * c + a) : 48'(ramp_data[c*N + a]);
                            e_cur.chan = (gi == 3) ? 3'(c) : 3'(ramp_chan[c*N + a]);
                            e_cur.last = (c == D - 1) && (a == N - 1);
                            sb.push_back(e_cur);
                        end
                    end
                end
                if (rden) begin
                    if (t_rden < 0) t_rden = cyc;
                    iss++;
                end
                if (out_val && t_val < 0) begin
                    t_val = cyc;
                    check(gi, "first_val_latency", 64'(t_val - t_rden), 64'(L + 1));
                end
                if (out_val && s_rdy[gi]) begin
                    acc++;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL dut%0d extra_word: got data %0d chan %0d, required no word", gi, out_data, out_chan);
                    end else begin
                        e_cur = sb.pop_front();
                        check(gi, "data", 64'(out_data), 64'(e_cur.data));
                        check(gi, "chan", 64'(out_chan), 64'(e_cur.chan));
                        check(gi, "last", 64'(out_last), 64'(e_cur.last));
                        $display("dut%0d word %0d chan %0d data %0d last %0b", gi, nword, out_chan, out_data, out_last);
                        nword++;
                    end
                end
                if (rden) check(gi, "outstanding_le_qdepth", 64'(iss - acc <= L + 1), 64'(1));
                if (u_dut.u_queue.i_push) check(gi, "push_when_full", 64'(u_dut.u_queue.o_count == L + 1), 64'(0));
                if (done && s_free[gi]) check(gi, "done_latency", 64'(cyc - t_start), 64'(D * N + L + 2));
            end
        end
    end

    int dc [4];
    int wcnt;

    task automatic kick(input int k);
        s_start[k] = 1'b1;
        s_load[k]  = 1'b1;
    endtask

    task automatic step_clear();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            s_start[k] = 1'b0;
            s_load[k]  = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            s_start[k] = 1'b0;
            s_rdy[k]   = 1'b1;
            s_load[k]  = 1'b0;
            s_free[k]  = 1'b1;
            dc[k]      = 0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check(k, "reset_outputs", 64'(s_outs[k]), 64'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Free-flowing ramp on the three small builds at once.
        for (int k = 0; k < 3; k++) kick(k);
        for (int t = 1; t <= 30; t++) begin
            step_clear();
            for (int k = 0; k < 3; k++) dc[k] += int'(s_outs[k][6]);
        end
        for (int k = 0; k < 3; k++) check(k, "ramp_done_count", 64'(dc[k]), 64'(1));

        // Backpressure: out_rdy low for cycles 3..10 after start.
        s_free[1] = 1'b0;
        dc[1] = 0;
        kick(1);
        for (int t = 1; t <= 40; t++) begin
            step_clear();
            s_rdy[1] = !(t >= 3 && t <= 10);
            dc[1] += int'(s_outs[1][6]);
        end
        s_rdy[1]  = 1'b1;
        s_free[1] = 1'b1;
        check(1, "backpressure_done_count", 64'(dc[1]), 64'(1));

        // start while busy and in the done cycle must both be ignored.
        dc[1] = 0;
        kick(1);
        for (int t = 1; t <= 40; t++) begin
            step_clear();
            if (t == 4) s_start[1] = 1'b1;
            if (s_outs[1][6]) begin
                dc[1]++;
                s_start[1] = 1'b1;
            end
        end
        step_clear();
        check(1, "ignored_start_done_count", 64'(dc[1]), 64'(1));
        check(1, "ignored_start_busy", 64'(s_outs[1][7]), 64'(0));

        // Reset mid-drain after five accepted words, then a clean drain.
        dc[1] = 0;
        wcnt  = 0;
        kick(1);
        for (int t = 1; t <= 8; t++) begin
            step_clear();
            wcnt += int'(s_outs[1][4]);
            dc[1] += int'(s_outs[1][6]);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check(1, "words_before_reset", 64'(wcnt), 64'(5));
        check(1, "aborted_drain_no_done", 64'(dc[1]), 64'(0));
        check(1, "outputs_after_mid_reset", 64'(s_outs[1]), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        kick(1);
        for (int t = 1; t <= 30; t++) begin
            step_clear();
            dc[1] += int'(s_outs[1][6]);
        end
        check(1, "post_reset_done_count", 64'(dc[1]), 64'(1));

        // Full 14x14x8 map with out_rdy high about 30% of cycles.
        s_free[3] = 1'b0;
        dc[3] = 0;
        kick(3);
        for (int t = 1; t <= 20000 && dc[3] == 0; t++) begin
            step_clear();
            s_rdy[3] = ($urandom_range(0, 99) < 30);
            dc[3] += int'(s_outs[3][6]);
        end
        s_rdy[3] = 1'b1;
        check(3, "big_map_done_count", 64'(dc[3]), 64'(1));
        check(3, "big_map_words_accepted", 64'(g_dut[3].nword), 64'(1568));
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
